// File: rtl/lsu_dmem_master_if.sv
// Data-memory port bundle between the load/store initiator (master) and data memory (slave).
interface lsu_dmem_master_if;
    logic        DataMem_access;
    logic        DataMem_RW;
    logic [3:0]  DataMem_Select;
    logic [31:0] DataMem_Address;
    logic [31:0] WriteDataMem;
    logic [31:0] ReadDataMem;
    logic        DataMem_Ready;

    modport master (
        output DataMem_access, DataMem_RW, DataMem_Select, DataMem_Address, WriteDataMem,
        input  ReadDataMem, DataMem_Ready
    );

    modport slave (
        input  DataMem_access, DataMem_RW, DataMem_Select, DataMem_Address, WriteDataMem,
        output ReadDataMem, DataMem_Ready
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// Single-outstanding load/store initiator: lane select, store replication, load extraction, alignment check.
// Define LSU_TIMEOUT_EN to abandon an access after TIMEOUT cycles without DataMem_Ready.
module lsu_dmem_master #(
    parameter int TAG_W   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err,
    lsu_dmem_master_if.master dmem
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t             state_q, state_d;
    logic               store_q, store_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
    logic               unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    logic        misaligned;
    logic        in_access;
    logic [3:0]  lane_sel;
    logic [31:0] wdata_rep;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;

    assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size[1])      && (req_addr[1:0] != 2'b00));

    always_comb begin
        lane_sel  = 4'b1111;
        wdata_rep = wdata_q;
        case (size_q)
            2'd0: begin
                lane_sel  = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane_sel  = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Loads shift the addressed lane down to bit 0, then extend per size and signedness.
    assign rd_shift = dmem.ReadDataMem >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rd_shift;
        case (size_q)
            2'd0: load_ext = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                      : {24'b0, rd_shift[7:0]};
            2'd1: load_ext = signed_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                      : {16'b0, rd_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tag_d    = tag_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    tag_d    = req_tag;
                    err_d    = misaligned;
                    rdata_d  = '0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                    state_d  = misaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dmem.DataMem_Ready) begin
                    if (!store_q) rdata_d = load_ext;
                    state_d = S_RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            store_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Bus and response outputs are gated by state so reset zeroes them immediately.
    assign in_access            = (state_q == S_ACCESS);
    assign req_ready            = (state_q == S_IDLE) && !rst;
    assign dmem.DataMem_access  = in_access;
    assign dmem.DataMem_RW      = in_access && store_q;
    assign dmem.DataMem_Select  = in_access ? lane_sel : 4'b0000;
    assign dmem.DataMem_Address = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem.WriteDataMem    = in_access ? wdata_rep : 32'h0;

    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_valid ? rdata_q : 32'h0;
    assign resp_tag   = resp_valid ? tag_q : '0;
    assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: byte-array memory slave, directed vector table, reset/idle-ready sequences, random traffic vs. byte-level model.
module tb_lsu_dmem_master;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_store, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [5:0]  req_tag;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [5:0]  resp_tag;

    lsu_dmem_master_if bus ();

    lsu_dmem_master #(.TAG_W(6), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
        .resp_err(resp_err),
        .dmem(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory slave: 256 bytes, combinational read, writes on Ready edge, programmable wait states.
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int  ready_delay = 0;
    int  acc_cnt;
    logic rdy_noise;
    logic mem_init;
    int  base;

    assign base = int'({bus.DataMem_Address[7:2], 2'b00});
    assign bus.ReadDataMem = {mem[base+3], mem[base+2], mem[base+1], mem[base]};
    assign bus.DataMem_Ready = rdy_noise | (bus.DataMem_access && (acc_cnt >= ready_delay));

    always @(posedge clk) begin
        if (!bus.DataMem_access) acc_cnt <= 0;
        else if (!bus.DataMem_Ready) acc_cnt <= acc_cnt + 1;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (bus.DataMem_access && bus.DataMem_RW && bus.DataMem_Ready) begin
            for (int k = 0; k < 4; k++)
                if (bus.DataMem_Select[k]) mem[base+k] <= bus.WriteDataMem[8*k +: 8];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: byte-granular memory, alignment by modulo, extension by arithmetic.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_misal(input logic [31:0] a, input logic [1:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
        int n = nbytes(sz);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[(a + i) % 256]) << (8 * i);
        if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    function automatic logic [3:0] model_sel(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] s = 0;
        for (int i = 0; i < nbytes(sz); i++) s[(a % 4) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdm(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] w = 0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    endtask

    task automatic run_req(input string nm, input bit st, input logic [1:0] sz, input bit sg,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [5:0] tag,
                           input int dly, input int lat, input logic [31:0] ed, input bit ee,
                           input logic [3:0] es, input logic [31:0] ew, input bit noise);
        int c = 0;
        int accs = 0;
        bit got = 0;
        ready_delay = dly;
        @(negedge clk);
        rdy_noise  = noise;
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_tag    = tag;
        #1 chk({nm, "/req_ready"}, 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rdy_noise = 1'b0;
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            if (bus.DataMem_access) begin
                accs++;
                chk({nm, "/bus"},
                    {bus.DataMem_RW, bus.DataMem_Select, bus.DataMem_Address, (st ? bus.WriteDataMem : 32'h0)},
                    {st, es, addr & 32'hFFFF_FFFC, (st ? ew : 32'h0)});
            end
            if (resp_valid) begin
                got = 1;
                chk({nm, "/latency"}, 64'(c), 64'(lat));
                chk({nm, "/resp"}, {resp_err, resp_tag, resp_data}, {ee, tag, ed});
            end
        end
        chk({nm, "/resp_seen"}, 64'(got), 64'(1));
        chk({nm, "/access_cycles"}, 64'(accs), 64'(lat - 1));
        @(negedge clk);
        chk({nm, "/one_pulse"}, {resp_valid, req_ready}, 2'b01);
        if (st && !ee)
            for (int i = 0; i < nbytes(sz); i++) ref_mem[(addr + i) % 256] = wd[8*i +: 8];
    endtask

    typedef struct {
        bit          st;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] addr;
        logic [31:0] wd;
        int          dly;
        logic [31:0] ed;
        bit          ee;
        logic [3:0]  es;
        logic [31:0] ew;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{0, 2'd2, 0, 32'h10, 32'h0,       0, 32'h13121110, 0, 4'hF, 32'h0};
        vt[1]  = '{0, 2'd0, 1, 32'h83, 32'h0,       0, 32'hFFFFFF83, 0, 4'h8, 32'h0};
        vt[2]  = '{0, 2'd0, 0, 32'h83, 32'h0,       1, 32'h00000083, 0, 4'h8, 32'h0};
        vt[3]  = '{1, 2'd1, 0, 32'h22, 32'h1234BEEF, 2, 32'h0,       0, 4'hC, 32'hBEEFBEEF};
        vt[4]  = '{0, 2'd2, 0, 32'h20, 32'h0,       0, 32'hBEEF2120, 0, 4'hF, 32'h0};
        vt[5]  = '{0, 2'd2, 0, 32'h06, 32'h0,       0, 32'h0,        1, 4'h0, 32'h0};
        vt[6]  = '{0, 2'd2, 0, 32'h40, 32'h0,       3, 32'h43424140, 0, 4'hF, 32'h0};
        vt[7]  = '{0, 2'd1, 1, 32'h22, 32'h0,       0, 32'hFFFFBEEF, 0, 4'hC, 32'h0};
        vt[8]  = '{1, 2'd1, 0, 32'h31, 32'hCAFE,    0, 32'h0,        1, 4'h0, 32'h0};
        vt[9]  = '{1, 2'd0, 1, 32'h45, 32'h777777A5, 0, 32'h0,       0, 4'h2, 32'hA5A5A5A5};
        vt[10] = '{0, 2'd3, 0, 32'h44, 32'h0,       1, 32'h4746A544, 0, 4'hF, 32'h0};
        vt[11] = '{0, 2'd1, 0, 32'h46, 32'h0,       0, 32'h00004746, 0, 4'hC, 32'h0};

        rst = 1'b1; mem_init = 1'b1; rdy_noise = 1'b0;
        req_valid = 0; req_store = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; req_tag = 0;
        model_reset();
        #2;
        chk("reset_outputs",
            {req_ready, resp_valid, resp_err, resp_data, bus.DataMem_access, bus.DataMem_RW, bus.DataMem_Select},
            '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
        #1 chk("ready_after_reset", 64'(req_ready), 64'(1));

        for (int i = 0; i < 12; i++) begin
            run_req($sformatf("vec%0d", i), vt[i].st, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd,
                    6'(i), vt[i].dly, (vt[i].ee ? 1 : vt[i].dly + 2),
                    vt[i].ed, vt[i].ee, vt[i].es, vt[i].ew, 1'b0);
        end

        // Ready asserted while idle must not provoke any response or bus activity.
        rdy_noise = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ready_ignored", {resp_valid, bus.DataMem_access}, 2'b00);
        end
        rdy_noise = 1'b0;

        // Reset in the middle of a long access: outputs drop at once, no response later.
        ready_delay = 20;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_addr = 32'h50; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_access_active", {bus.DataMem_access, bus.DataMem_RW}, 2'b11);
        #1 rst = 1'b1;
        #1 chk("mid_access_reset",
               {req_ready, resp_valid, bus.DataMem_access, bus.DataMem_RW, bus.DataMem_Select,
                bus.DataMem_Address, bus.WriteDataMem},
               '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abandoned_no_resp", {resp_valid, bus.DataMem_access, req_ready}, 3'b001);
        end
        chk("abandoned_no_write", 64'({mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}), 64'h53525150);

        // Random traffic against the byte-level model.
        for (int n = 0; n < 200; n++) begin
            bit          st  = 1'($urandom_range(0, 1));
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            bit          sg  = 1'($urandom_range(0, 1));
            logic [31:0] a   = $urandom;
            logic [31:0] wd  = $urandom;
            int          dly = $urandom_range(0, 4);
            bit          mis;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            mis = model_misal(a, sz);
            run_req("rand", st, sz, sg, a, wd, 6'($urandom), dly, (mis ? 1 : dly + 2),
                    ((st || mis) ? 32'h0 : model_load(a, sz, sg)), mis,
                    model_sel(a, sz), model_wdm(wd, sz), 1'($urandom_range(0, 1)));
        end

`ifdef LSU_TIMEOUT_EN
        run_req("timeout", 1'b0, 2'd2, 1'b0, 32'h60, 32'h0, 6'h2A, 100, 16,
                32'h0, 1'b1, 4'hF, 32'h0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
